vga_fb_scanout_80x60: RTL and testbench



---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing_gen.sv | 54 +++++
 rtl/vga_fb_scanout_80x60.sv | 76 +++++++
 tb/tb_vga_fb_scanout_80x60.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and framebuffer types for the scanout path.
// Pure definitions, no logic; the timing constants are the default module parameters.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  // *_SYNC_END is the first count after the sync pulse (exclusive bound)
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  localparam int FB_COLS  = 80;
  localparam int FB_ROWS  = 60;
  localparam int FB_DEPTH = (FB_ROWS - 1) * 128 + FB_COLS;

  typedef logic [12:0] fb_addr_t;
  typedef logic [7:0]  rgb332_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus h/v raster counters; raw active-low syncs are combinational
// from the counter registers, so they lead the registered outputs by one pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hs,
  output logic       vs
);

  localparam int HTOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == 10'(HTOT - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'(VTOT - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs     = !((h_cnt >= 10'(HS_LO)) && (h_cnt < 10'(HS_HI)));
  assign vs     = !((v_cnt >= 10'(VS_LO)) && (v_cnt < 10'(VS_HI)));

endmodule

// File: rtl/vga_fb_scanout_80x60.sv
// Scans the 80x60 framebuffer out as 640x480@60 VGA, each cell drawn as an 8x8 block.
// Address is combinational from the counters; colour/syncs are registered one pixel later.
module vga_fb_scanout_80x60
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int SCALE_SHIFT = 3
) (
  input  logic        CLK_50MHz,
  input  logic        RST_N,
  input  logic [7:0]  RD2,
  output logic [12:0] RA2,
  output logic [7:0]  VGA_RGB,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        FRAME_START
);

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  fb_addr_t   cell_addr;
  rgb332_t    pixel;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (CLK_50MHz),
    .rst_n  (RST_N),
    .pix_en (pix_en),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .hs     (hs_raw),
    .vs     (vs_raw)
  );

  // Address forced to 0 in blanking so the RAM never sees a row/col past the grid
  assign cell_addr = {6'(v_cnt >> SCALE_SHIFT), 7'(h_cnt >> SCALE_SHIFT)};
  assign RA2       = active ? cell_addr : '0;
  assign pixel     = active ? RD2 : '0;

  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      VGA_RGB     <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        VGA_RGB <= pixel;
        VGA_HS  <= hs_raw;
        VGA_VS  <= vs_raw;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout_80x60.sv
// Scoreboard bench: a raster model predicts every output per clock from the cycle count
// since reset release; a negedge monitor compares and also checks per-frame sync totals.
module tb_vga_fb_scanout_80x60;

  // Reduced raster so several frames fit in a short run; all boundaries still parametric
  localparam int HA = 64, HF = 4, HSW = 8, HB = 4;
  localparam int VA = 32, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME_CLKS = 2 * HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rd2;
  logic [12:0] ra2;
  logic [7:0]  rgb;
  logic        hs, vs, fs;

  int          mode = 0;
  logic [7:0]  mem [0:8191];

  int checks = 0;
  int failures = 0;

  vga_fb_scanout_80x60 #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
    .SCALE_SHIFT (3)
  ) dut (
    .CLK_50MHz   (clk),
    .RST_N       (rst_n),
    .RD2         (rd2),
    .RA2         (ra2),
    .VGA_RGB     (rgb),
    .VGA_HS      (hs),
    .VGA_VS      (vs),
    .FRAME_START (fs)
  );

  always #10 clk = ~clk;

  // Framebuffer memory model: asynchronous read of whatever RA2 the DUT presents
  assign rd2 = (mode == 0) ? ra2[7:0] :
               (mode == 1) ? 8'hFF :
               (mode == 2) ? ((ra2 == 13'd259) ? 8'hE0 : 8'h00) :
               mem[ra2];

  typedef struct {
    logic [7:0]  rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [12:0] ra;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [7:0] fb_val(int addr);
    case (mode)
      0:       return 8'(addr);
      1:       return 8'hFF;
      2:       return (addr == 2 * 128 + 3) ? 8'hE0 : 8'h00;
      default: return mem[addr];
    endcase
  endfunction

  // k = clock edges seen since reset release; pixel n is drawn from edge 2n+2
  function automatic exp_t expect_at(int k);
    exp_t e;
    int q, hq, vq, p, h, v;
    q  = k / 2;
    hq = q % HT;
    vq = (q / HT) % VT;
    e.ra = (hq < HA && vq < VA) ? 13'((vq / 8) * 128 + hq / 8) : 13'd0;
    if (k < 2) begin
      e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    end else begin
      p = k / 2 - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e.rgb = (h < HA && v < VA) ? fb_val((v / 8) * 128 + h / 8) : 8'h00;
      e.hs  = !(h >= HA + HF && h < HA + HF + HSW);
      e.vs  = !(v >= VA + VF && v < VA + VF + VSW);
      e.fs  = (k % 2 == 0) && (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
    end
  endtask

  // Reference model: pushes one expectation per clock, mid-way through the high phase
  initial begin : model
    int  k;
    logic r_at_edge;
    k = 0;
    forever begin
      @(posedge clk);
      r_at_edge = rst_n;
      #5;
      if (!r_at_edge || !rst_n) k = 0;
      else k++;
      exp_q.push_back(expect_at(k));
    end
  end

  // Monitor: pops and compares on every falling edge, plus whole-frame totals
  initial begin : monitor
    exp_t e;
    int   cyc, hs_low, vs_low;
    bit   have_prev;
    cyc = 0; hs_low = 0; vs_low = 0; have_prev = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("vga_rgb", int'(rgb), int'(e.rgb));
        chk("vga_hs", int'(hs), int'(e.hs));
        chk("vga_vs", int'(vs), int'(e.vs));
        chk("frame_start", int'(fs), int'(e.fs));
        chk("ra2", int'(ra2), int'(e.ra));
      end
      if (!rst_n) begin
        have_prev = 0; cyc = 0; hs_low = 0; vs_low = 0;
      end else begin
        cyc++;
        hs_low += int'(!hs);
        vs_low += int'(!vs);
        if (fs) begin
          if (have_prev) begin
            chk("frame_interval", cyc, FRAME_CLKS);
            chk("hs_low_per_frame", hs_low, VT * 2 * HSW);
            chk("vs_low_per_frame", vs_low, VSW * 2 * HT);
          end
          have_prev = 1; cyc = 0; hs_low = 0; vs_low = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int line;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mode  = 0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2 * FRAME_CLKS + 10) @(posedge clk);

    // Reset somewhere in the lower-middle of the visible area, asynchronously
    line = $urandom_range(20, 28);
    repeat (2 * HT * line + $urandom_range(0, 2 * HT - 1)) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (FRAME_CLKS + 10) @(posedge clk);

    for (int m = 1; m <= 3; m++) begin
      #3 rst_n = 1'b0;
      mode = m;
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (FRAME_CLKS + 10) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
